fixed_point_alu_core: RTL and testbench
=======================================

# fixed_point_alu_core

Sequential signed fixed-point arithmetic unit for the function-plotter datapath. It performs add, subtract, multiply, divide and integer power on two's-complement Q(I.F) operands. It is started by a one-cycle `start` pulse and signals completion with a level `done`. The stack machine uses it both for coordinate transforms and for RPN evaluation, always as `result = a op b`.

## Interface
- `INTEGER_PART_WIDTH`, default 8: integer bits, sign included.
- `FRACTIONAL_PART_WIDTH`, default 8: fraction bits. N = sum of the two (16 by default).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `start`  in  1: one-cycle request; ignored while busy.
- `op`  in  3: operation code. 000 PLUS, 001 SUB, 010 MUL, 011 DIV, 100 POW; 101–111 are unsupported.
- `a`, `b`  in  N each: signed Q(I.F) operands.
- `result`  out  N: signed Q(I.F) result; valid while `done` is high.
- `done`  out  1: completion level.

## Operation
- Reset: `done`=0, `result`=0, FSM=IDLE; any operation in flight is abandoned.
- In IDLE with `start`=1: latch `op`, `a` and `b`, then clear `done` on that same edge. Operand changes after this edge have no effect.
- `done` rises with a valid `result` and stays high until the next accepted `start`.
- FSM states: IDLE, MUL, DIV, POW, POW_INV. Every state returns to IDLE on completion.
- PLUS / SUB: `a+b` / `a-b` in N+1 bits, then range handling. Completes without leaving IDLE.
- MUL: the 2N-bit signed product is registered, then arithmetic-shifted right by F (truncation toward −inf), then range handling.
- DIV: sequential restoring division of |a|<<F by |b|, one quotient bit per cycle for N+F cycles. Sign is applied afterwards, truncating toward zero, then range handling.
- DIV with b=0: result = max positive if a≥0, most negative if a<0. Applies with and without the configuration macro.
- POW: exponent n = integer part of b (arithmetic `b>>>F`; the fraction is discarded).
  - Accumulator starts at 1.0 and is multiplied by a (same scaling as MUL) |n| times, one step per cycle.
  - If n<0, POW_INV then computes 1.0 / accumulator using the divider.
  - n=0 gives 1.0, including for a=0.
- Unsupported op: result 0.
- Range handling: see Configuration.

## Timing
Latency is counted in edges from the edge that samples `start` to the edge that sets `done`. `done` is 0 in between.
- PLUS / SUB / unsupported op: 1 edge.
- MUL: 2 edges.
- DIV: N+F+2 edges (26 with defaults).
- POW: 2+|n| edges; add N+F+1 when n<0.
- A caller that pulses `start`, waits one cycle, then polls `done` never sees a stale `done`.
- `start` while busy or at the same edge as completion: ignored, no queueing.
- Reset asserted mid-operation: immediate abort to the reset values.

## Configuration
- `FIXED_POINT_ALU_SATURATE_EN` defined: each out-of-range result clamps to 0x7FFF / 0x8000 (N=16). This covers every intermediate POW step.
- Not defined: the low N bits are kept (wrap-around), except for the divide-by-zero rule above.

## Structure
- Package `fixed_point_alu_pkg` holds:
  - op-code localparams (PLUS, SUB, MUL, DIV, POW);
  - the FSM state enum;
  - a helper that computes the max/min constants from N.
- Sub-module `fixed_point_divider` is the sequential unsigned restoring divider (start/done, N+F iterations). It is shared by DIV and POW_INV.
- Multiply and saturation are inline in the top.

## Test plan
Default parameters throughout; 1.0 = 0x0100.
- PLUS a=0x0280, b=0x0140 → 0x03C0, `done` after 1 edge. SUB a=0x0A00, b=0x1400 → 0xF600.
- MUL a=0x0180, b=0xFE00 → 0xFD00 after 2 edges. MUL a=0x0010, b=0x0010 → 0x0001.
- DIV a=0x0700, b=0x0200 → 0x0380 after 26 edges. DIV a=0xF900, b=0x0200 → 0xFC80. DIV a=0x0100, b=0 → 0x7FFF.
- POW a=0x0200, b=0x0300 → 0x0800 after 5 edges. POW a=0x0200, b=0xFF00 → 0x0080. POW a=0, b=0 → 0x0100.
- Overflow: PLUS a=0x7F00, b=0x0200 → 0x7FFF with the macro, 0x8100 without.
- Reset and handshake:
  - Drop `rst_n` mid-DIV → `done`=0 and `result`=0 at once.
  - A second `start` during DIV is ignored.
  - A new `start` after `done` clears `done` on the next edge.

Source files
------------

// File: rtl/fixed_point_alu_pkg.sv
// Shared op-codes, FSM states and range constants for the fixed-point ALU.
// Ports: none (package only).
package fixed_point_alu_pkg;

  localparam logic [2:0] OP_PLUS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_POW  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_POW,
    S_POW_INV
  } state_e;

  function automatic logic [63:0] max_pos(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n, start, dividend, divisor -> quotient, done (1-cycle pulse).
module fixed_point_divider #(
  parameter int N = 16,
  parameter int F = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N+F-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N+F-1:0] quotient,
  output logic           done
);
  import fixed_point_alu_pkg::*;

  localparam int DW = N + F;
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N:0]    shl;
  logic [N:0]    diff;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    shl    = {rem_q, quo_q[DW-1]};
    diff   = shl - {1'b0, dvs_q};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CW'(DW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // quo_q doubles as dividend shifter and quotient collector
      if (diff[N]) begin
        rem_d = shl[N-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end else begin
        rem_d = diff[N-1:0];
        quo_d = {quo_q[DW-2:0], 1'b1};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/fixed_point_alu_core.sv
// Sequential signed Q(I.F) ALU: add, sub, mul, div, integer power; start/done.
// Ports: clk, rst_n, start, op, a, b -> result, done. Macro: FIXED_POINT_ALU_SATURATE_EN.
module fixed_point_alu_core #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  localparam int N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         done
);
  import fixed_point_alu_pkg::*;

  localparam int F  = FRACTIONAL_PART_WIDTH;
  localparam int WW = 2 * N + 2;
  localparam int DW = N + F;
  localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));
  localparam logic [N-1:0] ONE     = N'(64'd1 << F);

  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? -x : x;
  endfunction

  function automatic logic [N-1:0] fit(input logic signed [WW-1:0] v);
`ifdef FIXED_POINT_ALU_SATURATE_EN
    logic ovf;
    ovf = v[WW-1:N-1] != {(WW-N+1){v[WW-1]}};
    if (ovf) return v[WW-1] ? MIN_NEG : MAX_POS;
    return v[N-1:0];
`else
    return v[N-1:0];
`endif
  endfunction

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [2:0]           op_q, op_d;
  logic signed [N-1:0]  a_q, a_d;
  logic signed [N-1:0]  b_q, b_d;
  logic signed [N-1:0]  acc_q, acc_d;
  logic [N-1:0]         cnt_q, cnt_d;
  logic signed [2*N-1:0] prod_q, prod_d;
  logic                 pneg_q, pneg_d;
  logic                 dneg_q, dneg_d;
  logic                 dzero_q, dzero_d;
  logic                 dzneg_q, dzneg_d;
  logic [N-1:0]         result_q, result_d;
  logic                 done_q, done_d;

  logic signed [WW-1:0]  a_x, b_x, sum_x, dif_x;
  logic signed [WW-1:0]  mul_x, pow_x, quo_x, quo_u;
  logic signed [2*N-1:0] pow_p;
  logic signed [N-1:0]   exp_n;
  logic [N-1:0]          dvd_mag, dvs_mag;
  logic                  div_start, div_done;
  logic [DW-1:0]         div_q;

  assign a_x   = WW'(a_q);
  assign b_x   = WW'(b_q);
  assign sum_x = a_x + b_x;
  assign dif_x = a_x - b_x;
  assign mul_x = WW'(prod_q >>> F);
  assign pow_p = (2*N)'(acc_q) * (2*N)'(a_q);
  assign pow_x = WW'(pow_p >>> F);
  assign exp_n = b_q >>> F;
  assign quo_u = WW'({1'b0, div_q});
  assign quo_x = dneg_q ? -quo_u : quo_u;

  // POW_INV divides 1.0 by the accumulator; DIV uses the operands
  always_comb begin
    if (state_q == S_POW) begin
      dvd_mag = ONE;
      dvs_mag = mag(acc_q);
    end else begin
      dvd_mag = mag(a_q);
      dvs_mag = mag(b_q);
    end
  end

  fixed_point_divider #(
    .N (N),
    .F (F)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend ({dvd_mag, {F{1'b0}}}),
    .divisor  (dvs_mag),
    .quotient (div_q),
    .done     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    pneg_d    = pneg_q;
    dneg_d    = dneg_q;
    dzero_d   = dzero_q;
    dzneg_d   = dzneg_q;
    result_d  = result_q;
    done_d    = done_q;
    div_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          unique case (1'b1)
            (op_q == OP_PLUS): begin
              result_d = fit(sum_x);
              done_d   = 1'b1;
            end
            (op_q == OP_SUB): begin
              result_d = fit(dif_x);
              done_d   = 1'b1;
            end
            (op_q == OP_MUL): begin
              prod_d  = (2*N)'(a_q) * (2*N)'(b_q);
              state_d = S_MUL;
            end
            (op_q == OP_DIV): begin
              div_start = 1'b1;
              dneg_d    = a_q[N-1] ^ b_q[N-1];
              dzero_d   = (b_q == '0);
              dzneg_d   = a_q[N-1];
              state_d   = S_DIV;
            end
            (op_q == OP_POW): begin
              acc_d   = ONE;
              cnt_d   = mag(exp_n);
              pneg_d  = exp_n[N-1];
              state_d = S_POW;
            end
            default: begin
              result_d = '0;
              done_d   = 1'b1;
            end
          endcase
        end else if (start) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          pend_d = 1'b1;
          done_d = 1'b0;
        end
      end
      S_MUL: begin
        result_d = fit(mul_x);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_POW: begin
        if (cnt_q != '0) begin
          acc_d = fit(pow_x);
          cnt_d = cnt_q - N'(1);
        end else if (pneg_q) begin
          div_start = 1'b1;
          dneg_d    = acc_q[N-1];
          dzero_d   = (acc_q == '0);
          dzneg_d   = 1'b0;
          state_d   = S_POW_INV;
        end else begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DIV, S_POW_INV: begin
        if (div_done) begin
          if (dzero_q) result_d = dzneg_q ? MIN_NEG : MAX_POS;
          else         result_d = fit(quo_x);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      pneg_q   <= 1'b0;
      dneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      dzneg_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      pneg_q   <= pneg_d;
      dneg_q   <= dneg_d;
      dzero_q  <= dzero_d;
      dzneg_q  <= dzneg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fixed_point_alu_core.sv
// Bench for fixed_point_alu_core: vector table, scoreboard queue, handshake cases.
// Ports: none (top-level bench).
module tb_fixed_point_alu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] result;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  vec_t vt [19];
  exp_t sb [$];

  fixed_point_alu_core #(
    .INTEGER_PART_WIDTH    (8),
    .FRACTIONAL_PART_WIDTH (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, input int pre);
    int   cyc;
    exp_t e;
    cyc = pre;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
    e = sb.pop_front();
    chk({nm, "_result"}, 32'(result), 32'(e.res));
    chk({nm, "_latency"}, cyc, e.lat);
  endtask

  task automatic launch(input string nm, input logic [2:0] o,
                        input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] r, input int lat);
    @(negedge clk);
    op    = o;
    a     = aa;
    b     = bb;
    start = 1'b1;
    sb.push_back('{res: r, lat: lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    chk({nm, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pre;
    vt[0]  = '{3'd0, 16'h0280, 16'h0140, 16'h03C0, 1};
    vt[1]  = '{3'd1, 16'h0A00, 16'h1400, 16'hF600, 1};
    vt[2]  = '{3'd2, 16'h0180, 16'hFE00, 16'hFD00, 2};
    vt[3]  = '{3'd2, 16'h0010, 16'h0010, 16'h0001, 2};
    vt[4]  = '{3'd2, 16'hFFFF, 16'h0080, 16'hFFFF, 2};
    vt[5]  = '{3'd3, 16'h0700, 16'h0200, 16'h0380, 26};
    vt[6]  = '{3'd3, 16'hF900, 16'h0200, 16'hFC80, 26};
    vt[7]  = '{3'd3, 16'h0100, 16'h0000, 16'h7FFF, 26};
    vt[8]  = '{3'd3, 16'hF900, 16'h0000, 16'h8000, 26};
    vt[9]  = '{3'd3, 16'hFF00, 16'h0300, 16'hFFAB, 26};
    vt[10] = '{3'd4, 16'h0200, 16'h0300, 16'h0800, 5};
    vt[11] = '{3'd4, 16'h0200, 16'hFF00, 16'h0080, 28};
    vt[12] = '{3'd4, 16'h0000, 16'h0000, 16'h0100, 2};
    vt[13] = '{3'd4, 16'h0180, 16'h0280, 16'h0240, 4};
    vt[14] = '{3'd4, 16'hFE00, 16'hFF00, 16'hFF80, 28};
    vt[15] = '{3'd5, 16'h1234, 16'h5678, 16'h0000, 1};
    vt[16] = '{3'd7, 16'h7FFF, 16'h7FFF, 16'h0000, 1};
`ifdef FIXED_POINT_ALU_SATURATE_EN
    vt[17] = '{3'd0, 16'h7F00, 16'h0200, 16'h7FFF, 1};
    vt[18] = '{3'd1, 16'h8000, 16'h0100, 16'h8000, 1};
`else
    vt[17] = '{3'd0, 16'h7F00, 16'h0200, 16'h8100, 1};
    vt[18] = '{3'd1, 16'h8000, 16'h0100, 16'h7F00, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      launch(nm, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);
      wait_done(nm, 0);
    end

    // second start during DIV must be dropped, not queued
    launch("busy", 3'd3, 16'h0700, 16'h0200, 16'h0380, 26);
    pre = 0;
    repeat (5) begin
      if (pre == 4) begin
        op    = 3'd0;
        a     = 16'h0001;
        b     = 16'h0001;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      pre++;
    end
    wait_done("busy", pre);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_hold_done", 32'(done), 32'd1);
    chk("busy_hold_result", 32'(result), 32'h0380);

    // new start after done clears done on the next edge
    launch("restart", 3'd0, 16'h0100, 16'h0100, 16'h0200, 1);
    wait_done("restart", 0);

    // asynchronous reset in the middle of a divide
    launch("rst_mid", 3'd3, 16'h0700, 16'h0200, 16'h0380, 26);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mid_idle", 32'(done), 32'd0);
    launch("post_rst", 3'd1, 16'h0300, 16'h0100, 16'h0200, 1);
    wait_done("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
